mmio_bridge: RTL and testbench

//   Memory-mapped I/O stage downstream of the Executs32 ALU result / dmemory32 data path.

---
 rtl/mmio_pkg.sv | 54 +++++
 rtl/mmio_bridge_if.sv | 12 +
 rtl/mmio_bridge_seg_scanner.sv | 57 +++++
 rtl/mmio_bridge.sv | 99 +++++++++
 tb/tb_mmio_bridge.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_pkg.sv
// Shared constants and helpers for the MMIO bridge: register offsets, reset
// patterns for the 7-segment outputs and the hex-to-segment decoder.
package mmio_pkg;

    localparam logic [9:0] OFF_LED   = 10'h060;
    localparam logic [9:0] OFF_SW    = 10'h070;
    localparam logic [9:0] OFF_SEG   = 10'h080;
    localparam logic [9:0] OFF_BLANK = 10'h084;

    localparam logic [7:0] SEG_EN_RST  = 8'hFE;
    localparam logic [7:0] SEG_LED_RST = 8'hC0;
    localparam logic [7:0] SEG_DARK    = 8'hFF;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_LED,
        REG_SW,
        REG_SEG,
        REG_BLANK
    } reg_sel_e;

    function automatic reg_sel_e decode_offset(input logic [9:0] off);
        case (off)
            OFF_LED:   return REG_LED;
            OFF_SW:    return REG_SW;
            OFF_SEG:   return REG_SEG;
            OFF_BLANK: return REG_BLANK;
            default:   return REG_NONE;
        endcase
    endfunction

    // Active-low segments {dp,g,f,e,d,c,b,a}; dp stays dark.
    function automatic logic [7:0] hex7seg(input logic [3:0] nib);
        case (nib)
            4'h0: return 8'hC0;
            4'h1: return 8'hF9;
            4'h2: return 8'hA4;
            4'h3: return 8'hB0;
            4'h4: return 8'h99;
            4'h5: return 8'h92;
            4'h6: return 8'h82;
            4'h7: return 8'hF8;
            4'h8: return 8'h80;
            4'h9: return 8'h90;
            4'hA: return 8'h88;
            4'hB: return 8'h83;
            4'hC: return 8'hC6;
            4'hD: return 8'hA1;
            4'hE: return 8'h86;
            default: return 8'h8E;
        endcase
    endfunction

endpackage

// File: rtl/mmio_bridge_if.sv
// CPU-side load/store port of the MMIO bridge; the CPU is master, the bridge slave.
interface mmio_bus_if;
    logic [31:0] addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] wdata;
    logic        io_sel;
    logic [31:0] rdata;

    modport master (output addr, mem_read, mem_write, wdata, input io_sel, rdata);
    modport slave  (input addr, mem_read, mem_write, wdata, output io_sel, rdata);
endinterface

// File: rtl/mmio_bridge_seg_scanner.sv
// Multiplexed 8-digit 7-segment driver: dwells SCAN_DIV cycles per digit and
// reloads enable and segment outputs together on each digit refresh edge.
module seg_scanner
    import mmio_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] value,
    input  logic [7:0]  blank,
    output logic [7:0]  seg_led_o,
    output logic [7:0]  seg_en_o
);

    localparam int unsigned    DIV_W    = 20;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       en_q, en_d;
    logic [7:0]       led_q, led_d;
    logic             tick;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + 1'b1;
        idx_d = idx_q;
        en_d  = en_q;
        led_d = led_q;
        if (tick) begin
            idx_d = idx_q + 3'd1;
            en_d  = ~(8'b1 << idx_d);
            led_d = blank[idx_d] ? SEG_DARK : hex7seg(value[{idx_d, 2'b00} +: 4]);
        end
    end

    // NOTE: state flops use non-blocking assignments; reset is asynchronous so digit 0 returns immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q <= '0;
            idx_q <= '0;
            en_q  <= SEG_EN_RST;
            led_q <= SEG_LED_RST;
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
            en_q  <= en_d;
            led_q <= led_d;
        end
    end

    assign seg_en_o  = en_q;
    assign seg_led_o = led_q;

endmodule

// File: rtl/mmio_bridge.sv
// I/O-window decoder for CPU loads/stores: LED, switch, 7-segment value and
// blanking registers, plus the registered read mux feeding the CPU load path.
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter logic [31:0] IO_BASE  = 32'hFFFF_FC00,
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned SW_W     = 24,
    parameter int unsigned LED_W    = 24
) (
    input  logic             clock,
    input  logic             reset,
    mmio_bus_if.slave        bus,
    input  logic [SW_W-1:0]  switch_i,
    output logic [LED_W-1:0] led_o,
    output logic [7:0]       seg_led_o,
    output logic [7:0]       seg_en_o
);

    logic             io_sel;
    reg_sel_e         reg_sel;
    logic             wr_en;
    logic             rd_en;
    logic [31:0]      rd_value;

    logic [LED_W-1:0] led_q, led_d;
    logic [31:0]      seg_q, seg_d;
    logic [7:0]       blank_q, blank_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [SW_W-1:0]  sw_meta_q, sw_meta_d;
    logic [SW_W-1:0]  sw_sync_q, sw_sync_d;

    always_comb begin
        io_sel  = (bus.addr[31:10] == IO_BASE[31:10]);
        reg_sel = decode_offset(bus.addr[9:0]);
        wr_en   = bus.mem_write && io_sel;
        rd_en   = bus.mem_read && io_sel;

        // Read mux sees pre-write state, so a same-cycle load+store returns the old value.
        rd_value = '0;
        case (reg_sel)
            REG_LED:   rd_value[LED_W-1:0] = led_q;
            REG_SW:    rd_value[SW_W-1:0]  = sw_sync_q;
            REG_SEG:   rd_value            = seg_q;
            REG_BLANK: rd_value[7:0]       = blank_q;
            default:   ;
        endcase
        rdata_d = rd_en ? rd_value : '0;

        led_d   = led_q;
        seg_d   = seg_q;
        blank_d = blank_q;
        if (wr_en) begin
            case (reg_sel)
                REG_LED:   led_d   = bus.wdata[LED_W-1:0];
                REG_SEG:   seg_d   = bus.wdata;
                REG_BLANK: blank_d = bus.wdata[7:0];
                default:   ;
            endcase
        end

        sw_meta_d = switch_i;
        sw_sync_d = sw_meta_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            led_q     <= '0;
            seg_q     <= '0;
            blank_q   <= '0;
            rdata_q   <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            led_q     <= led_d;
            seg_q     <= seg_d;
            blank_q   <= blank_d;
            rdata_q   <= rdata_d;
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
        end
    end

    assign bus.io_sel = io_sel;
    assign bus.rdata  = rdata_q;
    assign led_o      = led_q;

    seg_scanner #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scanner (
        .clock     (clock),
        .reset     (reset),
        .value     (seg_q),
        .blank     (blank_q),
        .seg_led_o (seg_led_o),
        .seg_en_o  (seg_en_o)
    );

endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge: a cycle-level behavioural model compared
// every cycle, plus directed literal checks for each feature.
module tb_mmio_bridge;

    localparam int          SCAN_DIV = 4;
    localparam logic [31:0] IO_BASE  = 32'hFFFF_FC00;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] switch_i = '0;
    logic [23:0] led_o;
    logic [7:0]  seg_led_o;
    logic [7:0]  seg_en_o;

    mmio_bus_if bus ();

    mmio_bridge #(
        .IO_BASE  (IO_BASE),
        .SCAN_DIV (SCAN_DIV),
        .SW_W     (24),
        .LED_W    (24)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .switch_i  (switch_i),
        .led_o     (led_o),
        .seg_led_o (seg_led_o),
        .seg_en_o  (seg_en_o)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    logic [7:0] hex_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // ---------------- behavioural model ----------------
    logic [23:0] m_led = '0;
    logic [31:0] m_seg = '0;
    logic [7:0]  m_blank = '0;
    logic [31:0] m_rdata = '0;
    logic [23:0] m_sw1 = '0, m_sw2 = '0;
    int          m_cyc = 0;
    int          m_idx = 0;
    logic [7:0]  m_en = 8'hFE;
    logic [7:0]  m_segled = 8'hC0;
    logic        model_on = 1'b0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_led = '0; m_seg = '0; m_blank = '0; m_rdata = '0;
            m_sw1 = '0; m_sw2 = '0;
            m_cyc = 0; m_idx = 0; m_en = 8'hFE; m_segled = 8'hC0;
        end else begin
            logic        io;
            logic [31:0] old;
            logic [3:0]  nib;
            io  = (bus.addr[31:10] == IO_BASE[31:10]);
            old = 32'h0;
            case (bus.addr[9:0])
                10'h060: old = {8'h00, m_led};
                10'h070: old = {8'h00, m_sw2};
                10'h080: old = m_seg;
                10'h084: old = {24'h0, m_blank};
                default: old = 32'h0;
            endcase
            m_rdata = (bus.mem_read && io) ? old : 32'h0;
            m_cyc++;
            if (m_cyc % SCAN_DIV == 0) begin
                m_idx    = (m_idx + 1) % 8;
                m_en     = ~(8'd1 << m_idx);
                nib      = 4'(m_seg >> (4 * m_idx));
                m_segled = m_blank[m_idx] ? 8'hFF : hex_tbl[nib];
            end
            if (bus.mem_write && io) begin
                case (bus.addr[9:0])
                    10'h060: m_led   = bus.wdata[23:0];
                    10'h080: m_seg   = bus.wdata;
                    10'h084: m_blank = bus.wdata[7:0];
                    default: ;
                endcase
            end
            m_sw2 = m_sw1;
            m_sw1 = switch_i;
        end
    end

    always @(posedge clock) begin
        #2;
        if (model_on && !reset) begin
            check("io_sel", {31'h0, bus.io_sel}, {31'h0, bus.addr[31:10] == IO_BASE[31:10]});
            check("rdata", bus.rdata, m_rdata);
            check("led", {8'h0, led_o}, {8'h0, m_led});
            check("seg_en", {24'h0, seg_en_o}, {24'h0, m_en});
            check("seg_led", {24'h0, seg_led_o}, {24'h0, m_segled});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic op(input logic [31:0] a, input logic rd, input logic wr, input logic [31:0] d);
        @(negedge clock);
        bus.addr = a; bus.mem_read = rd; bus.mem_write = wr; bus.wdata = d;
    endtask

    task automatic idle(input int n);
        repeat (n) op(32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic edge_sample();
        @(posedge clock);
        #3;
    endtask

    task automatic wait_en(input logic [7:0] target, input string name);
        int n = 0;
        while (seg_en_o !== target && n < 64) begin
            edge_sample();
            n++;
        end
        check(name, {24'h0, seg_en_o}, {24'h0, target});
    endtask

    task automatic walk(input logic [7:0] exp [8], input string tag);
        logic [7:0] e;
        logic [7:0] start;
        int         n;
        wait_en(8'h7F, {tag, "_sync7"});
        wait_en(8'hFE, {tag, "_sync0"});
        for (int k = 0; k <= 8; k++) begin
            e = ~(8'd1 << (k % 8));
            check({tag, "_en"}, {24'h0, seg_en_o}, {24'h0, e});
            check({tag, "_seg"}, {24'h0, seg_led_o}, {24'h0, exp[k % 8]});
            if (k < 8) begin
                start = seg_en_o;
                n = 0;
                while (seg_en_o === start && n < 20) begin
                    edge_sample();
                    n++;
                end
                check({tag, "_dwell"}, n, 32'd4);
            end
        end
    endtask

    logic [7:0] exp_plain [8] = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};
    logic [7:0] exp_blank [8] = '{8'hFF, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'hFF};

    initial begin
        bus.addr = '0; bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.wdata = '0;

        // Reset values
        repeat (2) @(negedge clock);
        #1;
        check("rst_led", {8'h0, led_o}, 32'h0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_seg_en", {24'h0, seg_en_o}, 32'hFE);
        check("rst_seg_led", {24'h0, seg_led_o}, 32'hC0);
        @(negedge clock);
        reset = 1'b0;
        model_on = 1'b1;

        // LED store and load
        op(32'hFFFF_FC60, 1'b0, 1'b1, 32'h00A5_A5A5);
        edge_sample();
        check("led_store", {8'h0, led_o}, 32'h00A5_A5A5);
        op(32'hFFFF_FC60, 1'b1, 1'b0, 32'h0);
        edge_sample();
        check("led_load", bus.rdata, 32'h00A5_A5A5);
        idle(1);
        edge_sample();
        check("rdata_idle", bus.rdata, 32'h0);

        // Switch synchroniser, read-only
        @(negedge clock);
        switch_i = 24'h123456;
        idle(2);
        op(32'hFFFF_FC70, 1'b1, 1'b0, 32'h0);
        edge_sample();
        check("sw_load", bus.rdata, 32'h0012_3456);
        op(32'hFFFF_FC70, 1'b0, 1'b1, 32'hDEAD_BEEF);
        op(32'hFFFF_FC70, 1'b1, 1'b0, 32'h0);
        edge_sample();
        check("sw_ro", bus.rdata, 32'h0012_3456);

        // Unmapped offset reads zero
        op(32'hFFFF_FC64, 1'b1, 1'b1, 32'h5555_5555);
        edge_sample();
        check("unmapped", bus.rdata, 32'h0);

        // Scanner walk with SEG
        op(32'hFFFF_FC80, 1'b0, 1'b1, 32'h89AB_CDEF);
        idle(1);
        walk(exp_plain, "scan");

        // Blanking
        op(32'hFFFF_FC84, 1'b0, 1'b1, 32'hFFFF_FF81);
        op(32'hFFFF_FC84, 1'b1, 1'b0, 32'h0);
        edge_sample();
        check("blank_load", bus.rdata, 32'h0000_0081);
        idle(1);
        walk(exp_blank, "blank");
        op(32'hFFFF_FC84, 1'b0, 1'b1, 32'h0);

        // Same-cycle load+store returns old value
        op(32'hFFFF_FC80, 1'b0, 1'b1, 32'h11);
        op(32'hFFFF_FC80, 1'b1, 1'b1, 32'h22);
        edge_sample();
        check("rw_old", bus.rdata, 32'h11);
        op(32'hFFFF_FC80, 1'b1, 1'b0, 32'h0);
        edge_sample();
        check("rw_new", bus.rdata, 32'h22);

        // Store outside the window
        op(32'h0000_0060, 1'b0, 1'b1, 32'h0001_2345);
        #1;
        check("outside_sel", {31'h0, bus.io_sel}, 32'h0);
        edge_sample();
        check("outside_led", {8'h0, led_o}, 32'h00A5_A5A5);

        // Reset mid-scan at digit 5
        op(32'hFFFF_FC80, 1'b0, 1'b1, 32'h7654_3210);
        idle(1);
        wait_en(8'hDF, "mid_digit5");
        op(32'hFFFF_FC60, 1'b0, 1'b1, 32'h00FF_FFFF);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_en", {24'h0, seg_en_o}, 32'hFE);
        check("mid_rst_seg", {24'h0, seg_led_o}, 32'hC0);
        check("mid_rst_led", {8'h0, led_o}, 32'h0);
        check("mid_rst_rdata", bus.rdata, 32'h0);
        edge_sample();
        check("rst_write_lost", {8'h0, led_o}, 32'h0);
        idle(1);
        reset = 1'b0;
        op(32'hFFFF_FC80, 1'b1, 1'b0, 32'h0);
        edge_sample();
        check("post_rst_seg", bus.rdata, 32'h0);
        check("post_rst_en0", {24'h0, seg_en_o}, 32'hFE);
        idle(1);
        repeat (2) edge_sample();
        check("post_rst_en1", {24'h0, seg_en_o}, 32'hFD);
        check("post_rst_led1", {24'h0, seg_led_o}, 32'hC0);

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
